cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit.sv | 167 ++++++++++++++++
 tb/tb_cond_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition-evaluation unit.
// Holds the ALU flag register {N,Z,C,V}, evaluates a 4-bit condition code
// against it, and returns the result over a one-entry valid/ready response
// stage. Consumed "execute" responses are counted.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       flags_in,
    input  logic             flag_we,
    input  logic             req_valid,
    input  logic [3:0]       req_cond,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_exec,
    output logic [3:0]       flags_out,
    output logic [CNT_W-1:0] exec_count
);

    // Response-stage states: IDLE = no response held, FULL = response held.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Condition codes.
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Registered state and next-state values.
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             resp_exec_q;
    logic             resp_exec_d;
    logic [CNT_W-1:0] exec_count_q;
    logic [CNT_W-1:0] exec_count_d;

    // Handshake and evaluation helpers.
    logic       accept;
    logic       consume;
    logic [3:0] eval_flags;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_true;

    // Ready: always in IDLE, in FULL only when the held response drains this
    // cycle; forced low while reset is asserted.
    always_comb begin
        req_ready = 1'b0;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                req_ready = 1'b1;
            end else begin
                req_ready = resp_ready;
            end
        end
    end

    assign accept  = req_valid & req_ready;
    assign consume = (state_q == ST_FULL) & resp_ready & !reset;

    // Flags seen by the evaluator: a same-cycle flag write is forwarded so the
    // request sees the value being loaded this edge.
    always_comb begin
        eval_flags = flags_q;
        if (flag_we) begin
            eval_flags = flags_in;
        end
    end

    assign flag_n = eval_flags[3];
    assign flag_z = eval_flags[2];
    assign flag_c = eval_flags[1];
    assign flag_v = eval_flags[0];

    // Condition table lookup.
    always_comb begin
        cond_true = 1'b0;
        case (req_cond)
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = !flag_z;
            COND_CS: cond_true = flag_c;
            COND_CC: cond_true = !flag_c;
            COND_MI: cond_true = flag_n;
            COND_PL: cond_true = !flag_n;
            COND_VS: cond_true = flag_v;
            COND_VC: cond_true = !flag_v;
            COND_HI: cond_true = flag_c & !flag_z;
            COND_LS: cond_true = !flag_c | flag_z;
            COND_GE: cond_true = (flag_n == flag_v);
            COND_LT: cond_true = (flag_n != flag_v);
            COND_GT: cond_true = !flag_z & (flag_n == flag_v);
            COND_LE: cond_true = flag_z | (flag_n != flag_v);
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // Flag register load is independent of the request handshake.
    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d = flags_in;
        end
    end

    // Response-stage next state; the held result only changes on an accept,
    // so stalls and flag writes leave a pending result untouched.
    always_comb begin
        state_d     = state_q;
        resp_exec_d = resp_exec_q;
        if (accept) begin
            state_d     = ST_FULL;
            resp_exec_d = cond_true;
        end else if (consume) begin
            state_d = ST_IDLE;
        end
    end

    // Count consumed "execute" responses, wrapping naturally at 2^CNT_W.
    always_comb begin
        exec_count_d = exec_count_q;
        if (consume && resp_exec_q) begin
            exec_count_d = exec_count_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= 4'b0000;
            state_q      <= ST_IDLE;
            resp_exec_q  <= 1'b0;
            exec_count_q <= '0;
        end else begin
            flags_q      <= flags_d;
            state_q      <= state_d;
            resp_exec_q  <= resp_exec_d;
            exec_count_q <= exec_count_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_exec  = resp_exec_q;
    assign flags_out  = flags_q;
    assign exec_count = exec_count_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit (CNT_W=4 so counter wrap is reachable). Expected
// responses are queued at accept time and compared while they are presented.
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       flags_in = 4'h0;
    logic             flag_we = 1'b0;
    logic             req_valid = 1'b0;
    logic [3:0]       req_cond = 4'h0;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_exec;
    logic [3:0]       flags_out;
    logic [CNT_W-1:0] exec_count;

    typedef struct {
        logic [3:0] cond;
        logic       exec;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_flags = 4'h0;
    logic [3:0] m_cnt = 4'h0;
    int         total_cnt = 0;
    int         bad_cnt = 0;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flags_in   (flags_in),
        .flag_we    (flag_we),
        .req_valid  (req_valid),
        .req_cond   (req_cond),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_exec  (resp_exec),
        .flags_out  (flags_out),
        .exec_count (exec_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor/model: inputs are stable here, half a cycle before the edge
    // that commits them.
    always @(negedge clk) begin
        logic       acc;
        logic       cons;
        logic [3:0] ef;
        exp_t       e;
        if (reset) begin
            check_eq("rdy_in_rst", 32'(req_ready), 32'd0);
            exp_q.delete();
            m_flags = 4'h0;
            m_cnt   = 4'h0;
        end else begin
            check_eq("req_ready", 32'(req_ready), 32'((exp_q.size() == 0) || resp_ready));
            check_eq("resp_valid", 32'(resp_valid), 32'(exp_q.size() > 0));
            check_eq("flags_out", 32'(flags_out), 32'(m_flags));
            check_eq("exec_count", 32'(exec_count), 32'(m_cnt));
            if (exp_q.size() > 0) begin
                check_eq("resp_exec", 32'(resp_exec), 32'(exp_q[0].exec));
            end
            cons = (exp_q.size() > 0) && resp_ready;
            acc  = req_valid && ((exp_q.size() == 0) || resp_ready);
            ef   = flag_we ? flags_in : m_flags;
            if (cons) begin
                e = exp_q.pop_front();
                if (e.exec) m_cnt = m_cnt + 4'd1;
                $display("rsp cond=%h exec=%0d cnt=%0d", e.cond, e.exec, m_cnt);
            end
            if (acc) begin
                e.cond = req_cond;
                e.exec = cond_ref(req_cond, ef);
                exp_q.push_back(e);
            end
            if (flag_we) m_flags = flags_in;
        end
    end

    task automatic apply(input logic fw, input logic [3:0] fin, input logic rv,
                         input logic [3:0] rc, input logic rr);
        flag_we    = fw;
        flags_in   = fin;
        req_valid  = rv;
        req_cond   = rc;
        resp_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            apply(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        apply(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_flags", 32'(flags_out), 32'd0);
        check_eq("rst_cnt", 32'(exec_count), 32'd0);
        check_eq("rst_vld", 32'(resp_valid), 32'd0);

        // Flag load then EQ, one-cycle latency.
        apply(1'b1, 4'b0100, 1'b0, 4'h0, 1'b1);
        apply(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
        check_eq("eq_vld", 32'(resp_valid), 32'd1);
        check_eq("eq_exec", 32'(resp_exec), 32'd1);
        check_eq("eq_flags", 32'(flags_out), 32'b0100);
        drain();

        // Forwarding: flags 0, same-cycle write of N with MI.
        apply(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1);
        apply(1'b1, 4'b1000, 1'b1, 4'h4, 1'b1);
        check_eq("fwd_exec", 32'(resp_exec), 32'd1);
        check_eq("fwd_flags", 32'(flags_out), 32'b1000);
        drain();

        // Full sweep, back-to-back.
        for (int f = 0; f < 16; f++) begin
            apply(1'b1, 4'(f), 1'b0, 4'h0, 1'b1);
            for (int c = 0; c < 16; c++) begin
                apply(1'b0, 4'h0, 1'b1, 4'(c), 1'b1);
            end
        end
        drain();

        // Stall: response held 3 cycles with flag writes and a waiting request.
        apply(1'b1, 4'b0100, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 4'(4'b0001 + i), 1'b1, 4'h1, 1'b0);
            check_eq("stall_rdy", 32'(req_ready), 32'd0);
            check_eq("stall_exec", 32'(resp_exec), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 4'h0, 1'b1, 4'(4'hA + i), 1'b1);
        end
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            apply(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                  1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                  1'($urandom_range(3, 0) != 0));
        end
        drain();

        // Asynchronous reset between edges with a response pending.
        apply(1'b1, 4'b1111, 1'b1, 4'hE, 1'b0);
        check_eq("arst_pre_vld", 32'(resp_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_vld", 32'(resp_valid), 32'd0);
        check_eq("arst_flags", 32'(flags_out), 32'd0);
        check_eq("arst_cnt", 32'(exec_count), 32'd0);
        check_eq("arst_rdy", 32'(req_ready), 32'd0);
        do_reset();

        // Counter wrap: 17 AL consumed, then NV leaves count unchanged.
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
        end
        drain();
        check_eq("wrap_cnt", 32'(exec_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'h0, 1'b1, 4'hF, 1'b1);
        end
        drain();
        check_eq("nv_cnt", 32'(exec_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
